// File: rtl/uart_cmd_dispatcher_pkg.sv
// Shared constants, types and validation helpers for the UART command dispatcher.
package uart_cmd_pkg;

    localparam logic [7:0] TAIL   = 8'hBC;
    localparam logic [7:0] HEADER = 8'h40;
    localparam logic [7:0] RESP_LEN_BYTE = 8'h02;

    // Command codes
    localparam logic [7:0] CMD_BRIGHT = 8'h01;
    localparam logic [7:0] CMD_MODE   = 8'h02;
    localparam logic [7:0] CMD_GAIN   = 8'h03;
    localparam logic [7:0] CMD_BYPASS = 8'h04;
    localparam logic [7:0] CMD_COMMIT = 8'h05;
    localparam logic [7:0] CMD_STATUS = 8'h10;

    // Response status codes
    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_TAIL = 8'h01;
    localparam logic [7:0] ST_BAD_LEN  = 8'h02;
    localparam logic [7:0] ST_BAD_CODE = 8'h03;

    // Configuration reset values
    localparam logic [7:0]  RST_BRIGHT = 8'h80;
    localparam logic [3:0]  RST_MODE   = 4'h0;
    localparam logic [15:0] RST_GAIN   = 16'h0100;
    localparam logic        RST_BYPASS = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Only the low 16 parameter bits are ever consumed, so only those are stored.
    typedef struct packed {
        logic [7:0]  code;
        logic [7:0]  len;
        logic [15:0] para;
        logic [7:0]  check;
    } cmd_t;

    typedef struct packed {
        logic [7:0]  bright;
        logic [3:0]  mode;
        logic [15:0] gain;
        logic        bypass;
    } cfg_t;

    localparam cfg_t CFG_RST = '{bright: RST_BRIGHT, mode: RST_MODE,
                                 gain: RST_GAIN, bypass: RST_BYPASS};

    // Required frame length per code; zero marks an unknown code.
    function automatic logic [7:0] req_len(input logic [7:0] code);
        case (code)
            CMD_BRIGHT, CMD_MODE, CMD_BYPASS: return 8'd2;
            CMD_GAIN:                         return 8'd3;
            CMD_COMMIT, CMD_STATUS:           return 8'd1;
            default:                          return 8'd0;
        endcase
    endfunction

    // Tail is checked first, then the code, then the length.
    function automatic logic [7:0] cmd_status(input cmd_t c);
        if (c.check != TAIL)          return ST_BAD_TAIL;
        if (req_len(c.code) == 8'd0)  return ST_BAD_CODE;
        if (c.len != req_len(c.code)) return ST_BAD_LEN;
        return ST_OK;
    endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_if.sv
// Command-in / response-byte-out bundle between the UART side and the dispatcher.
interface uart_cmd_dispatcher_if;
    logic        i_cmd_valid;
    logic [7:0]  i_cmdcode;
    logic [7:0]  i_cmd_len;
    logic [31:0] i_para;
    logic [7:0]  i_check;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;

    modport master (
        output i_cmd_valid, i_cmdcode, i_cmd_len, i_para, i_check, i_tx_ready,
        input  o_tx_valid, o_tx_data
    );

    modport slave (
        input  i_cmd_valid, i_cmdcode, i_cmd_len, i_para, i_check, i_tx_ready,
        output o_tx_valid, o_tx_data
    );
endinterface

// File: rtl/uart_cmd_dispatcher_resp_framer.sv
// 5-byte acknowledge serializer: HEADER, 0x02, code|0x80, status, TAIL.
module m_resp_framer
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] code,
    input  logic [7:0] status,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       done
);

    logic [2:0] idx_q;
    logic [7:0] code_q;
    logic [7:0] status_q;
    logic       hs;

    assign hs   = tx_valid & tx_ready;
    assign done = hs & (idx_q == 3'd4);

    function automatic logic [7:0] byte_at(input logic [2:0] i, input logic [7:0] c,
                                           input logic [7:0] s);
        case (i)
            3'd0:    return HEADER;
            3'd1:    return RESP_LEN_BYTE;
            3'd2:    return c;
            3'd3:    return s;
            default: return TAIL;
        endcase
    endfunction

    // Data is registered so it holds steady while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            idx_q    <= 3'd0;
            code_q   <= 8'h00;
            status_q <= 8'h00;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= HEADER;
            idx_q    <= 3'd0;
            code_q   <= code | 8'h80;
            status_q <= status;
        end else if (hs) begin
            if (idx_q == 3'd4) begin
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
                idx_q    <= 3'd0;
            end else begin
                idx_q   <= idx_q + 3'd1;
                tx_data <= byte_at(idx_q + 3'd1, code_q, status_q);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Validates command frames, maintains shadow/active dimming config, sends acks.
module uart_cmd_dispatcher
    import uart_cmd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_dispatcher_if.slave bus,
    input  logic                 i_vsync,
    output logic [7:0]           o_cfg_bright,
    output logic [3:0]           o_cfg_mode,
    output logic [15:0]          o_cfg_gain,
    output logic                 o_cfg_bypass,
    output logic                 o_cfg_update,
    output logic [7:0]           o_drop_cnt
);

    state_t     state_q, state_d;
    cmd_t       in_cmd, cur_q, buf_q;
    logic       buf_full_q;
    logic       take_cmd;
    cfg_t       shadow_q, active_q;
    logic       pending_q, update_q, vsync_q;
    logic [7:0] drop_q;
    logic [7:0] status_w, resp_status;
    logic       exec_ok, write_ok, commit_req, do_commit, resp_done;
    logic       unused_para;

    assign in_cmd      = {bus.i_cmdcode, bus.i_cmd_len, bus.i_para[15:0], bus.i_check};
    assign unused_para = ^bus.i_para[31:16];

    assign status_w   = cmd_status(cur_q);
    assign exec_ok    = (state_q == S_EXEC) && (status_w == ST_OK);
    assign write_ok   = exec_ok && (cur_q.code inside {CMD_BRIGHT, CMD_MODE, CMD_GAIN, CMD_BYPASS});
    // vsync edge and an executed commit in the same cycle collapse to one commit.
    assign commit_req = (i_vsync & ~vsync_q) | (exec_ok && cur_q.code == CMD_COMMIT);
    assign do_commit  = commit_req & pending_q;
    assign resp_status = (exec_ok && cur_q.code == CMD_STATUS) ? drop_q : status_w;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: buffered command has priority over a fresh one in IDLE
    always_comb begin
        state_d  = state_q;
        take_cmd = 1'b0;
        case (state_q)
            S_IDLE: if (buf_full_q || bus.i_cmd_valid) begin
                take_cmd = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: if (resp_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Current command latch, one-entry buffer and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            if (take_cmd) cur_q <= buf_full_q ? buf_q : in_cmd;
            if (state_q == S_IDLE) begin
                // Buffer drains into cur; a same-cycle arrival refills it.
                if (buf_full_q) begin
                    if (bus.i_cmd_valid) buf_q <= in_cmd;
                    else                 buf_full_q <= 1'b0;
                end
            end else if (bus.i_cmd_valid) begin
                if (!buf_full_q) begin
                    buf_q      <= in_cmd;
                    buf_full_q <= 1'b1;
                end else if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end
        end
    end

    // Shadow writes, pending flag and shadow->active commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= CFG_RST;
            active_q  <= CFG_RST;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q  <= i_vsync;
            update_q <= do_commit;
            // Commit copies the pre-write shadow; a same-cycle write stays pending.
            if (do_commit) active_q <= shadow_q;
            if (write_ok) begin
                case (cur_q.code)
                    CMD_BRIGHT: shadow_q.bright <= cur_q.para[7:0];
                    CMD_MODE:   shadow_q.mode   <= cur_q.para[3:0];
                    CMD_GAIN:   shadow_q.gain   <= cur_q.para[15:0];
                    default:    shadow_q.bypass <= cur_q.para[0];
                endcase
                pending_q <= 1'b1;
            end else if (do_commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    m_resp_framer u_framer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == S_EXEC),
        .code     (cur_q.code),
        .status   (resp_status),
        .tx_ready (bus.i_tx_ready),
        .tx_valid (bus.o_tx_valid),
        .tx_data  (bus.o_tx_data),
        .done     (resp_done)
    );

    assign o_cfg_bright = active_q.bright;
    assign o_cfg_mode   = active_q.mode;
    assign o_cfg_gain   = active_q.gain;
    assign o_cfg_bypass = active_q.bypass;
    assign o_cfg_update = update_q;
    assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed + randomized bench for uart_cmd_dispatcher with a behavioural model.
module tb_uart_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_vsync = 1'b0;
    logic [7:0]  o_cfg_bright;
    logic [3:0]  o_cfg_mode;
    logic [15:0] o_cfg_gain;
    logic        o_cfg_bypass;
    logic        o_cfg_update;
    logic [7:0]  o_drop_cnt;

    uart_cmd_dispatcher_if bus();

    uart_cmd_dispatcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .i_vsync      (i_vsync),
        .o_cfg_bright (o_cfg_bright),
        .o_cfg_mode   (o_cfg_mode),
        .o_cfg_gain   (o_cfg_gain),
        .o_cfg_bypass (o_cfg_bypass),
        .o_cfg_update (o_cfg_update),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: shadow/active settings, pending flag, drop count
    logic [7:0]  m_sh_b, m_ac_b;
    logic [3:0]  m_sh_m, m_ac_m;
    logic [15:0] m_sh_g, m_ac_g;
    logic        m_sh_y, m_ac_y;
    logic        m_pend, m_upd;
    logic [7:0]  m_drop;
    logic [7:0]  rx [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_sh_b = 8'h80; m_sh_m = 4'h0; m_sh_g = 16'h0100; m_sh_y = 1'b0;
        m_ac_b = 8'h80; m_ac_m = 4'h0; m_ac_g = 16'h0100; m_ac_y = 1'b0;
        m_pend = 1'b0; m_upd = 1'b0; m_drop = 8'h00;
    endfunction

    function automatic void m_commit();
        if (m_pend) begin
            m_ac_b = m_sh_b; m_ac_m = m_sh_m; m_ac_g = m_sh_g; m_ac_y = m_sh_y;
            m_pend = 1'b0;
            m_upd  = 1'b1;
        end
    endfunction

    function automatic int need_len(input logic [7:0] code);
        case (code)
            8'h01, 8'h02, 8'h04: return 2;
            8'h03:               return 3;
            8'h05, 8'h10:        return 1;
            default:             return -1;
        endcase
    endfunction

    // Returns the status byte the ack frame should carry.
    function automatic logic [7:0] m_exec(input logic [7:0] code, input logic [7:0] len,
                                          input logic [31:0] para, input logic [7:0] chkb);
        int n;
        n = need_len(code);
        if (chkb != 8'hBC) return 8'h01;
        if (n < 0)         return 8'h03;
        if (int'(len) != n) return 8'h02;
        case (code)
            8'h01: begin m_sh_b = para[7:0];  m_pend = 1'b1; end
            8'h02: begin m_sh_m = para[3:0];  m_pend = 1'b1; end
            8'h03: begin m_sh_g = para[15:0]; m_pend = 1'b1; end
            8'h04: begin m_sh_y = para[0];    m_pend = 1'b1; end
            8'h05: m_commit();
            8'h10: return m_drop;
            default: ;
        endcase
        return 8'h00;
    endfunction

    task automatic check_cfg(input string tag);
        chk(tag, {o_cfg_bright, o_cfg_mode, o_cfg_gain, o_cfg_bypass, o_cfg_update},
                 {m_ac_b, m_ac_m, m_ac_g, m_ac_y, m_upd});
    endtask

    task automatic send(input logic [7:0] code, input logic [7:0] len,
                        input logic [31:0] para, input logic [7:0] chkb);
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmdcode   = code;
        bus.i_cmd_len   = len;
        bus.i_para      = para;
        bus.i_check     = chkb;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    // Collect n bytes with random ready; optionally stall 10 cycles at byte stall_idx.
    task automatic recv(input int n, input int stall_idx);
        int got = 0, cyc = 0, hold = 0;
        bit prev_wait = 0;
        logic [7:0] prev_d = 8'h00;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (prev_wait) chk("tx_hold", {o_tx_valid_w(), bus.o_tx_data}, {1'b1, prev_d});
            prev_wait = 0;
            if (bus.o_tx_valid) begin
                if (got == stall_idx && hold < 10) begin
                    bus.i_tx_ready = 1'b0;
                    hold++;
                end else begin
                    bus.i_tx_ready = ($urandom_range(0, 3) != 0);
                end
                if (bus.i_tx_ready) begin
                    rx[got] = bus.o_tx_data;
                    got++;
                end else begin
                    prev_wait = 1;
                    prev_d    = bus.o_tx_data;
                end
            end else begin
                bus.i_tx_ready = 1'b0;
            end
        end
        if (got < n) chk("recv_timeout", got, n);
        @(negedge clk);
        bus.i_tx_ready = 1'b0;
    endtask

    function automatic logic o_tx_valid_w();
        return bus.o_tx_valid;
    endfunction

    task automatic chk_frame(input string tag, input logic [7:0] code, input logic [7:0] st);
        chk(tag, {rx[0], rx[1], rx[2], rx[3], rx[4]}, {8'h40, 8'h02, code | 8'h80, st, 8'hBC});
    endtask

    // Issue a command to an idle DUT, check T+2 state and the whole ack frame.
    task automatic do_cmd(input string tag, input logic [7:0] code, input logic [7:0] len,
                          input logic [31:0] para, input logic [7:0] chkb, input int stall);
        logic [7:0] st;
        m_upd = 1'b0;
        st = m_exec(code, len, para, chkb);
        send(code, len, para, chkb);
        @(negedge clk);
        check_cfg({tag, "_cfg"});
        chk({tag, "_first"}, {bus.o_tx_valid, bus.o_tx_data}, {1'b1, 8'h40});
        recv(5, stall);
        chk_frame({tag, "_frame"}, code, st);
    endtask

    task automatic pulse_vsync(input string tag);
        m_upd = 1'b0;
        m_commit();
        @(negedge clk);
        i_vsync = 1'b1;
        @(negedge clk);
        check_cfg({tag, "_commit"});
        i_vsync = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse_end"}, o_cfg_update, 1'b0);
    endtask

    initial begin
        logic [7:0] st_a, st_b;
        logic [7:0] codes [8];
        codes[0] = 8'h01; codes[1] = 8'h02; codes[2] = 8'h03; codes[3] = 8'h04;
        codes[4] = 8'h05; codes[5] = 8'h10; codes[6] = 8'h7F; codes[7] = 8'h00;

        bus.i_cmd_valid = 1'b0; bus.i_cmdcode = '0; bus.i_cmd_len = '0;
        bus.i_para = '0; bus.i_check = '0; bus.i_tx_ready = 1'b0;
        m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_cfg_bright, o_cfg_mode, o_cfg_gain, o_cfg_bypass, o_cfg_update,
                              bus.o_tx_valid, bus.o_tx_data, o_drop_cnt},
                             {8'h80, 4'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write, active holds until vsync
        do_cmd("bright", 8'h01, 8'd2, 32'h0000_00C0, 8'hBC, -1);
        chk("bright_before_vsync", o_cfg_bright, 8'h80);
        pulse_vsync("vs1");
        chk("bright_after_vsync", o_cfg_bright, 8'hC0);

        // Rejected frames leave everything untouched
        do_cmd("badlen", 8'h03, 8'd2, 32'h0000_1234, 8'hBC, -1);
        do_cmd("badtail", 8'h01, 8'd2, 32'h0000_0055, 8'h00, -1);
        do_cmd("badcode", 8'h7F, 8'd1, 32'h0, 8'hBC, -1);
        pulse_vsync("vs_none");

        // Immediate commit, no vsync
        do_cmd("gain", 8'h03, 8'd3, 32'h0000_0180, 8'hBC, -1);
        do_cmd("commit", 8'h05, 8'd1, 32'h0, 8'hBC, -1);
        chk("gain_committed", o_cfg_gain, 16'h0180);

        // Back-pressure mid-frame
        do_cmd("stall", 8'h02, 8'd2, 32'h0000_0007, 8'hBC, 2);

        // Overflow: A runs, B buffered, C dropped
        m_upd = 1'b0;
        st_a = m_exec(8'h02, 8'd2, 32'h5, 8'hBC);
        send(8'h02, 8'd2, 32'h5, 8'hBC);
        send(8'h04, 8'd2, 32'h1, 8'hBC);
        send(8'h01, 8'd2, 32'h33, 8'hBC);
        st_b = m_exec(8'h04, 8'd2, 32'h1, 8'hBC);
        m_drop = m_drop + 8'd1;
        recv(5, -1);
        chk_frame("ovf_a", 8'h02, st_a);
        recv(5, -1);
        chk_frame("ovf_b", 8'h04, st_b);
        chk("drop_cnt", o_drop_cnt, m_drop);
        do_cmd("status", 8'h10, 8'd1, 32'h0, 8'hBC, -1);
        chk("status_byte", rx[3], 8'h01);

        // Reset in the middle of a response
        m_upd = 1'b0;
        void'(m_exec(8'h01, 8'd2, 32'h99, 8'hBC));
        send(8'h01, 8'd2, 32'h99, 8'hBC);
        recv(2, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {o_cfg_bright, o_cfg_mode, o_cfg_gain, o_cfg_bypass, o_cfg_update,
                               bus.o_tx_valid, bus.o_tx_data, o_drop_cnt},
                              {8'h80, 4'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        bus.i_tx_ready = 1'b0;
        rst_n = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        chk("midrst_no_resume", bus.o_tx_valid, 1'b0);

        // vsync edge in the EXEC cycle of a write commits only the old shadow
        do_cmd("pre", 8'h01, 8'd2, 32'h11, 8'hBC, -1);
        m_upd = 1'b0;
        m_commit();
        void'(m_exec(8'h01, 8'd2, 32'h22, 8'hBC));
        send(8'h01, 8'd2, 32'h22, 8'hBC);
        i_vsync = 1'b1;
        @(negedge clk);
        check_cfg("collide");
        i_vsync = 1'b0;
        recv(5, -1);
        chk_frame("collide_frame", 8'h01, 8'h00);
        pulse_vsync("vs_after");
        chk("collide_new", o_cfg_bright, 8'h22);

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] c, l, k;
            logic [31:0] p;
            c = codes[$urandom_range(0, 7)];
            l = ($urandom_range(0, 3) != 0 && need_len(c) > 0) ? 8'(need_len(c))
                                                               : 8'($urandom_range(0, 5));
            k = ($urandom_range(0, 7) != 0) ? 8'hBC : 8'($urandom_range(0, 255));
            p = $urandom;
            do_cmd("rnd", c, l, p, k, ($urandom_range(0, 4) == 0) ? 1 : -1);
            if (i % 3 == 2) pulse_vsync("rnd_vs");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
